// File: rtl/modbus_pkg.sv
// Shared definitions for the Modbus RTU receive path: FSM state
// encoding, the fixed addresses and CRC constants, and the bytewise
// CRC-16/MODBUS update used by the crc16_d8 engine.
package modbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RECV     = 2'd1,
        ST_WAIT_CRC = 2'd2,
        ST_REPORT   = 2'd3
    } rx_state_t;

    localparam logic [7:0]  MB_BROADCAST_ADDR = 8'h00;
    localparam logic [15:0] CRC16_INIT        = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUE     = 16'h0000;
    // Reflected form of polynomial 0x8005, processed LSB first
    localparam logic [15:0] CRC16_POLY        = 16'hA001;

    // One byte of CRC-16/MODBUS: xor the byte into the low half, then
    // eight shift-right steps with the reflected polynomial.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc,
                                               input logic [7:0]  data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ CRC16_POLY;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/modbus_rx_frame_ctrl_if.sv
// Byte stream in from the UART receiver / silence timer, and the
// per-frame verdict out to the command decoder.
interface modbus_rx_frame_ctrl_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_end;

    logic       busy;
    logic       frame_done;
    logic       frame_ok;
    logic       crc_err;
    logic       len_err;
    logic       addr_match;
    logic [7:0] frame_addr;
    logic [7:0] frame_func;
    logic [8:0] frame_len;
    logic       rx_drop;

    // Byte source side: drives the stream, observes the verdict
    modport master (
        output rx_data,
        output rx_valid,
        output frame_end,
        input  busy,
        input  frame_done,
        input  frame_ok,
        input  crc_err,
        input  len_err,
        input  addr_match,
        input  frame_addr,
        input  frame_func,
        input  frame_len,
        input  rx_drop
    );

    // Frame controller side
    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_end,
        output busy,
        output frame_done,
        output frame_ok,
        output crc_err,
        output len_err,
        output addr_match,
        output frame_addr,
        output frame_func,
        output frame_len,
        output rx_drop
    );

endinterface

// File: rtl/crc16_d8.sv
// Registered CRC-16/MODBUS engine, one byte per enabled cycle.
// crc_init has priority over crc_en; the controller never asserts both.
module crc16_d8
    import modbus_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        crc_init,
    input  logic        crc_en,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);

    logic [15:0] crc_q;

    // Running CRC register: reload on init, absorb one byte on enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= CRC16_INIT;
        end else if (crc_init) begin
            crc_q <= CRC16_INIT;
        end else if (crc_en) begin
            crc_q <= crc16_byte(crc_q, data);
        end
    end

    assign crc_out = crc_q;

endmodule

// File: rtl/modbus_rx_frame_ctrl.sv
// Receive-side frame controller for the Modbus RTU slave. Feeds each
// frame through one CRC engine, counts bytes, and at frame end reports
// one verdict covering CRC residue, length and slave address.
module modbus_rx_frame_ctrl
    import modbus_pkg::*;
#(
    parameter logic [7:0] SLAVE_ADDR = 8'h01,
    parameter int         MIN_LEN    = 4,
    parameter int         MAX_LEN    = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    modbus_rx_frame_ctrl_if.slave   bus
);

    // Count limits in the counter's own width; MAX_LEN+1 is the
    // saturation value that marks an over-long frame
    localparam logic [8:0] LEN_MIN = 9'(MIN_LEN);
    localparam logic [8:0] LEN_MAX = 9'(MAX_LEN);
    localparam logic [8:0] LEN_SAT = 9'(MAX_LEN + 1);

    rx_state_t   state_q, state_d;
    logic [8:0]  count_q, count_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  func_q, func_d;

    logic        crc_init;
    logic        crc_en;
    logic [15:0] crc_result;
    logic        crc_rst_n;
    logic        results_load;

    logic        crc_bad;
    logic        len_bad;
    logic        addr_ok;

    logic        frame_ok_q;
    logic        crc_err_q;
    logic        len_err_q;
    logic        addr_match_q;
    logic [7:0]  frame_addr_q;
    logic [7:0]  frame_func_q;
    logic [8:0]  frame_len_q;

    assign crc_rst_n = !rst;

    crc16_d8 u_crc (
        .clk      (clk),
        .rst_n    (crc_rst_n),
        .crc_init (crc_init),
        .crc_en   (crc_en),
        .data     (bus.rx_data),
        .crc_out  (crc_result)
    );

    // State, byte count and captured header bytes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            addr_q  <= '0;
            func_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            func_q  <= func_d;
        end
    end

    // Next state, byte accounting and engine control; a byte arriving
    // with frame_end in RECV is absorbed before the frame closes
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        addr_d       = addr_q;
        func_d       = func_q;
        crc_en       = 1'b0;
        crc_init     = 1'b0;
        results_load = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.rx_valid) begin
                    crc_en  = 1'b1;
                    count_d = 9'd1;
                    addr_d  = bus.rx_data;
                    func_d  = 8'h00;
                    state_d = ST_RECV;
                end
            end

            ST_RECV: begin
                if (bus.rx_valid) begin
                    if (count_q < LEN_MAX) begin
                        crc_en  = 1'b1;
                        count_d = count_q + 9'd1;
                    end else begin
                        count_d = LEN_SAT;
                    end
                    if (count_q == 9'd1) begin
                        func_d = bus.rx_data;
                    end
                end
                if (bus.frame_end) begin
                    state_d = ST_WAIT_CRC;
                end
            end

            ST_WAIT_CRC: begin
                results_load = 1'b1;
                state_d      = ST_REPORT;
            end

            ST_REPORT: begin
                crc_init = 1'b1;
                state_d  = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Frame checks, valid once the engine has absorbed the last byte
    always_comb begin
        crc_bad = (crc_result != CRC16_RESIDUE);
        len_bad = (count_q < LEN_MIN) || (count_q > LEN_MAX);
        addr_ok = (addr_q == SLAVE_ADDR) || (addr_q == MB_BROADCAST_ADDR);
    end

    // Verdict registers, loaded at the end of WAIT_CRC and held until
    // the next frame reports
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_ok_q   <= 1'b0;
            crc_err_q    <= 1'b0;
            len_err_q    <= 1'b0;
            addr_match_q <= 1'b0;
            frame_addr_q <= '0;
            frame_func_q <= '0;
            frame_len_q  <= '0;
        end else if (results_load) begin
            frame_ok_q   <= !crc_bad && !len_bad && addr_ok;
            crc_err_q    <= crc_bad;
            len_err_q    <= len_bad;
            addr_match_q <= addr_ok;
            frame_addr_q <= addr_q;
            frame_func_q <= func_q;
            frame_len_q  <= count_q;
        end
    end

    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.frame_done = (state_q == ST_REPORT);
    assign bus.rx_drop    = bus.rx_valid &&
                            ((state_q == ST_WAIT_CRC) || (state_q == ST_REPORT));

    assign bus.frame_ok   = frame_ok_q;
    assign bus.crc_err    = crc_err_q;
    assign bus.len_err    = len_err_q;
    assign bus.addr_match = addr_match_q;
    assign bus.frame_addr = frame_addr_q;
    assign bus.frame_func = frame_func_q;
    assign bus.frame_len  = frame_len_q;

endmodule

// File: tb/tb_modbus_rx_frame_ctrl.sv
// Bench for modbus_rx_frame_ctrl: directed frames go in from one process,
// the expected verdict for each is queued, and a monitor compares the
// DUT's verdict whenever frame_done pulses.
module tb_modbus_rx_frame_ctrl;

    typedef struct {
        logic       ok;
        logic       crc_err;
        logic       len_err;
        logic       addr_match;
        logic [7:0] addr;
        logic [7:0] func;
        logic [8:0] len;
    } exp_t;

    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    exp_t       sb_q[$];
    logic [7:0] tx_q[$];

    modbus_rx_frame_ctrl_if bus ();

    modbus_rx_frame_ctrl #(
        .SLAVE_ADDR (8'h01),
        .MIN_LEN    (4),
        .MAX_LEN    (256)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 100 MHz-style free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    function automatic exp_t mkExp(input logic ok, input logic crc_err,
                                   input logic len_err, input logic addr_match,
                                   input logic [7:0] addr, input logic [7:0] func,
                                   input logic [8:0] len);
        exp_t e;
        e.ok = ok; e.crc_err = crc_err; e.len_err = len_err;
        e.addr_match = addr_match; e.addr = addr; e.func = func; e.len = len;
        return e;
    endfunction

    // Builds stimulus only: CRC-16/MODBUS over the first n bytes of tx_q
    function automatic logic [15:0] crcOf(input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {8'h00, tx_q[i]};
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
            end
        end
        return c;
    endfunction

    task automatic loadBase(input logic [7:0] addr);
        tx_q.delete();
        tx_q.push_back(addr);
        tx_q.push_back(8'h03);
        tx_q.push_back(8'h00);
        tx_q.push_back(8'h00);
        tx_q.push_back(8'h00);
        tx_q.push_back(8'h01);
    endtask

    task automatic appendCrc();
        logic [15:0] c;
        c = crcOf(tx_q.size());
        tx_q.push_back(c[7:0]);
        tx_q.push_back(c[15:8]);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"},       bus.busy,       0);
        checkOutput({tag, "_frame_done"}, bus.frame_done, 0);
        checkOutput({tag, "_frame_ok"},   bus.frame_ok,   0);
        checkOutput({tag, "_crc_err"},    bus.crc_err,    0);
        checkOutput({tag, "_len_err"},    bus.len_err,    0);
        checkOutput({tag, "_addr_match"}, bus.addr_match, 0);
        checkOutput({tag, "_frame_addr"}, bus.frame_addr, 0);
        checkOutput({tag, "_frame_func"}, bus.frame_func, 0);
        checkOutput({tag, "_frame_len"},  bus.frame_len,  0);
        checkOutput({tag, "_rx_drop"},    bus.rx_drop,    0);
    endtask

    // Sends tx_q as one frame, queues its expected verdict and checks
    // the frame_end -> WAIT_CRC -> REPORT -> IDLE timing along the way
    task automatic applyStimulus(input string name, input exp_t exp,
                                 input bit merge_last, input bit drop_byte);
        sb_q.push_back(exp);
        for (int i = 0; i < tx_q.size(); i++) begin
            bus.rx_data   = tx_q[i];
            bus.rx_valid  = 1'b1;
            bus.frame_end = merge_last && (i == tx_q.size() - 1);
            @(posedge clk); #1;
        end
        bus.rx_valid = 1'b0;
        if (!merge_last) begin
            bus.frame_end = 1'b1;
            @(posedge clk); #1;
        end
        bus.frame_end = 1'b0;
        if (drop_byte) begin
            bus.rx_data  = 8'h5A;
            bus.rx_valid = 1'b1;
        end
        @(negedge clk);
        checkOutput({name, "_wait_busy"}, bus.busy, 1);
        checkOutput({name, "_wait_done"}, bus.frame_done, 0);
        checkOutput({name, "_wait_drop"}, bus.rx_drop, drop_byte);
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        @(negedge clk);
        checkOutput({name, "_report_done"}, bus.frame_done, 1);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput({name, "_idle_busy"}, bus.busy, 0);
        checkOutput({name, "_idle_done"}, bus.frame_done, 0);
        @(posedge clk); #1;
    endtask

    // Scoreboard monitor: every frame_done must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.frame_done) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_frame_done", bus.frame_done, 0);
            end else begin
                e = sb_q.pop_front();
                checkOutput("frame_ok",   bus.frame_ok,   e.ok);
                checkOutput("crc_err",    bus.crc_err,    e.crc_err);
                checkOutput("len_err",    bus.len_err,    e.len_err);
                checkOutput("addr_match", bus.addr_match, e.addr_match);
                checkOutput("frame_addr", bus.frame_addr, e.addr);
                checkOutput("frame_func", bus.frame_func, e.func);
                checkOutput("frame_len",  bus.frame_len,  e.len);
            end
        end
    end

    initial begin
        logic [7:0] short_lo;
        logic [15:0] c1;

        rst           = 1'b1;
        bus.rx_data   = 8'h00;
        bus.rx_valid  = 1'b0;
        bus.frame_end = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] good frame 01 03 00 00 00 01 84 0A");
        loadBase(8'h01); tx_q.push_back(8'h84); tx_q.push_back(8'h0A);
        applyStimulus("good", mkExp(1, 0, 0, 1, 8'h01, 8'h03, 9'd8), 0, 0);

        $display("[TB] corrupted last CRC byte");
        loadBase(8'h01); tx_q.push_back(8'h84); tx_q.push_back(8'h0B);
        applyStimulus("badcrc", mkExp(0, 1, 0, 1, 8'h01, 8'h03, 9'd8), 0, 0);

        $display("[TB] foreign address 02");
        loadBase(8'h02); appendCrc();
        applyStimulus("addr02", mkExp(0, 0, 0, 0, 8'h02, 8'h03, 9'd8), 0, 0);

        $display("[TB] broadcast address 00");
        loadBase(8'h00); appendCrc();
        applyStimulus("addr00", mkExp(1, 0, 0, 1, 8'h00, 8'h03, 9'd8), 0, 0);

        $display("[TB] 3-byte frame");
        tx_q.delete(); tx_q.push_back(8'h01);
        c1 = crcOf(1);
        short_lo = c1[7:0];
        appendCrc();
        applyStimulus("short", mkExp(0, 0, 1, 1, 8'h01, short_lo, 9'd3), 0, 0);

        $display("[TB] 300-byte frame, CRC closes at byte 256");
        tx_q.delete(); tx_q.push_back(8'h01);
        for (int i = 1; i < 254; i++) tx_q.push_back(8'(i));
        appendCrc();
        for (int i = 0; i < 44; i++) tx_q.push_back(8'hAA);
        applyStimulus("long", mkExp(0, 0, 1, 1, 8'h01, 8'h01, 9'd257), 0, 0);

        $display("[TB] good frame after overlong frame");
        loadBase(8'h01); tx_q.push_back(8'h84); tx_q.push_back(8'h0A);
        applyStimulus("after_long", mkExp(1, 0, 0, 1, 8'h01, 8'h03, 9'd8), 0, 0);

        $display("[TB] last byte coincident with frame_end");
        loadBase(8'h01); tx_q.push_back(8'h84); tx_q.push_back(8'h0A);
        applyStimulus("merged", mkExp(1, 0, 0, 1, 8'h01, 8'h03, 9'd8), 1, 0);

        $display("[TB] byte during WAIT_CRC is dropped");
        loadBase(8'h01); tx_q.push_back(8'h84); tx_q.push_back(8'h0A);
        applyStimulus("drop", mkExp(1, 0, 0, 1, 8'h01, 8'h03, 9'd8), 0, 1);

        $display("[TB] reset after 4 bytes");
        loadBase(8'h01);
        for (int i = 0; i < 4; i++) begin
            bus.rx_data  = tx_q[i];
            bus.rx_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.rx_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checkAllZero("midreset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] good frame after reset");
        loadBase(8'h01); tx_q.push_back(8'h84); tx_q.push_back(8'h0A);
        applyStimulus("after_reset", mkExp(1, 0, 0, 1, 8'h01, 8'h03, 9'd8), 0, 0);

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        checkOutput("scoreboard_drained", 16'(sb_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
